// File: rtl/prbs7_pkg.sv
// Shared definitions for the PRBS7 (x^7+x^6+1) stream checker: tap positions,
// FSM encoding and fixed counter widths.
package prbs7_pkg;

  localparam int unsigned HIST_W = 7;
  localparam int unsigned TAP_HI = 7;
  localparam int unsigned TAP_LO = 6;
  localparam int unsigned FILL_W = 3;
  localparam int unsigned ERR_W  = 16;

  localparam logic [FILL_W-1:0] FILL_FULL = 3'd7;
  localparam logic [ERR_W-1:0]  ERR_MAX   = 16'hFFFF;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // History bit 0 is the newest sample; the x^TAP_LO term lands TAP_HI-TAP_LO
  // samples back and the x^TAP_HI term on the oldest sample.
  function automatic logic [HIST_W-1:0] tap_mask();
    logic [HIST_W-1:0] m;
    m = '0;
    m[TAP_HI-TAP_LO-1] = 1'b1;
    m[TAP_HI-1]        = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/prbs7_predict.sv
// Combinational next-bit predictor for the PRBS7 sequence from a 7-bit history.
module prbs7_predict
  import prbs7_pkg::*;
(
  input  logic [HIST_W-1:0] hist,
  output logic              expected
);

  assign expected = ^(hist & tap_mask());

endmodule

// File: rtl/prbs7_checker.sv
// PRBS7 receive checker: acquires lock on a clean stream, then free-runs its
// own predictor and counts bit errors, dropping lock on a burst of errors.
module prbs7_checker
  import prbs7_pkg::*;
#(
  parameter int unsigned LOCK_MATCHES = 16,
  parameter int unsigned WINDOW       = 32,
  parameter int unsigned UNLOCK_ERRS  = 4
)
(
  input  logic             clk,
  input  logic             reset,
  input  logic             data_in,
  input  logic             valid_in,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int unsigned MATCH_W = $clog2(LOCK_MATCHES + 1);
  localparam int unsigned WIN_W   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int unsigned WERR_W  = $clog2(UNLOCK_ERRS + 1);

  state_t              state_r, state_s;
  logic [HIST_W-1:0]   hist_r, hist_s;
  logic [FILL_W-1:0]   fill_r, fill_s;
  logic [MATCH_W-1:0]  match_r, match_s;
  logic [WIN_W-1:0]    win_cnt_r, win_cnt_s;
  logic [WERR_W-1:0]   win_err_r, win_err_s, werr_sum_s;
  logic [ERR_W-1:0]    err_cnt_r, err_cnt_s;
  logic                err_pulse_r, err_pulse_s;
  logic                err_inc_s;
  logic                expected_s;
  logic                mismatch_s;

  prbs7_predict u_predict (
    .hist     (hist_r),
    .expected (expected_s)
  );

  assign mismatch_s = data_in ^ expected_s;

  // Acquisition / tracking FSM with history, fill, match and window counters
  always_comb begin
    state_s     = state_r;
    hist_s      = hist_r;
    fill_s      = fill_r;
    match_s     = match_r;
    win_cnt_s   = win_cnt_r;
    win_err_s   = win_err_r;
    err_pulse_s = 1'b0;
    err_inc_s   = 1'b0;
    werr_sum_s  = win_err_r + WERR_W'(mismatch_s);
    if (valid_in) begin
      case (state_r)
        SEARCH: begin
          hist_s    = {hist_r[HIST_W-2:0], data_in};
          win_cnt_s = '0;
          win_err_s = '0;
          if (fill_r != FILL_FULL) begin
            fill_s  = fill_r + FILL_W'(1'b1);
            match_s = '0;
          end else if (!mismatch_s && (hist_r != '0)) begin
            match_s = match_r + MATCH_W'(1'b1);
            if (match_r == MATCH_W'(LOCK_MATCHES - 1)) begin
              state_s = LOCKED;
            end else begin
              state_s = SEARCH;
            end
          end else begin
            match_s = '0;
          end
        end
        LOCKED: begin
          // Free-run on the prediction so one flipped bit costs one error.
          hist_s      = {hist_r[HIST_W-2:0], expected_s};
          err_pulse_s = mismatch_s;
          err_inc_s   = mismatch_s;
          if (werr_sum_s == WERR_W'(UNLOCK_ERRS)) begin
            state_s   = SEARCH;
            fill_s    = '0;
            match_s   = '0;
            win_cnt_s = '0;
            win_err_s = '0;
          end else if (win_cnt_r == WIN_W'(WINDOW - 1)) begin
            win_cnt_s = '0;
            win_err_s = '0;
          end else begin
            win_cnt_s = win_cnt_r + WIN_W'(1'b1);
            win_err_s = werr_sum_s;
          end
        end
        default: begin
          state_s = SEARCH;
        end
      endcase
    end else begin
      err_pulse_s = 1'b0;
    end
  end

  // Saturating error counter; clear takes priority over an increment
  always_comb begin
    err_cnt_s = err_cnt_r;
    if (clear_cnt) begin
      err_cnt_s = '0;
    end else if (err_inc_s && (err_cnt_r != ERR_MAX)) begin
      err_cnt_s = err_cnt_r + ERR_W'(1'b1);
    end else begin
      err_cnt_s = err_cnt_r;
    end
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= SEARCH;
      hist_r      <= '0;
      fill_r      <= '0;
      match_r     <= '0;
      win_cnt_r   <= '0;
      win_err_r   <= '0;
      err_cnt_r   <= '0;
      err_pulse_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      hist_r      <= hist_s;
      fill_r      <= fill_s;
      match_r     <= match_s;
      win_cnt_r   <= win_cnt_s;
      win_err_r   <= win_err_s;
      err_cnt_r   <= err_cnt_s;
      err_pulse_r <= err_pulse_s;
    end
  end

  assign locked    = (state_r == LOCKED);
  assign err_pulse = err_pulse_r;
  assign err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_prbs7_checker.sv
// Scoreboard bench for prbs7_checker: stimulus queues expected lock/unlock/error
// events and snapshots; a monitor compares them as the DUT presents them.
module tb_prbs7_checker;

  logic        clk = 1'b0;
  logic        reset, data_in, valid_in, clear_cnt;
  logic        locked, err_pulse;
  logic [15:0] err_cnt;

  always #5 clk = ~clk;

  prbs7_checker #(.LOCK_MATCHES(16), .WINDOW(32), .UNLOCK_ERRS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .clear_cnt (clear_cnt),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt)
  );

  typedef struct {
    string       name;
    logic        exp_locked;
    logic [15:0] exp_cnt;
  } snap_t;

  int    n_pass  = 0;
  int    n_total = 0;
  int    vcount  = 0;
  logic  snap_req = 1'b0;
  logic  prev_locked = 1'b0;
  logic [6:0] gen = 7'b0000001;
  int    lock_q[$];
  int    fall_q[$];
  int    pulse_q[$];
  snap_t snap_q[$];

  task automatic check(input string name, input longint got, input longint exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
  endtask

  task automatic drive(input logic d, input logic v, input logic c);
    @(negedge clk);
    data_in = d; valid_in = v; clear_cnt = c;
    @(posedge clk);
    if (v) vcount++;
  endtask

  // Next lfsr7 bit (b[n] = b[n-1] ^ b[n-7]), optionally inverted.
  task automatic send_prbs(input logic inv, input logic clr);
    logic b;
    b = gen[0] ^ gen[6];
    gen = {gen[5:0], b};
    drive(b ^ inv, 1'b1, clr);
  endtask

  task automatic idle();
    drive(1'($urandom_range(1, 0)), 1'b0, 1'b0);
  endtask

  task automatic snap(input string name, input logic l, input logic [15:0] c);
    snap_t s;
    s.name = name; s.exp_locked = l; s.exp_cnt = c;
    snap_q.push_back(s);
    @(negedge clk);
    valid_in = 1'b0; clear_cnt = 1'b0; snap_req = 1'b1;
    @(negedge clk);
    snap_req = 1'b0;
  endtask

  task automatic do_reset(input logic was_locked);
    if (was_locked) fall_q.push_back(vcount);
    @(negedge clk);
    reset = 1'b1; valid_in = 1'b1; data_in = 1'b1; clear_cnt = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0; valid_in = 1'b0;
    vcount = 0;
  endtask

  // Monitor: sample outputs 1 time unit after each rising edge.
  always begin
    snap_t s;
    int    e;
    @(posedge clk);
    #1;
    if ((locked === 1'b1) && (prev_locked !== 1'b1)) begin
      if (lock_q.size() == 0) check("unexpected_lock", vcount, -1);
      else begin e = lock_q.pop_front(); check("lock_at_valid_bit", vcount, e); end
    end
    if ((locked === 1'b0) && (prev_locked === 1'b1)) begin
      if (fall_q.size() == 0) check("unexpected_unlock", vcount, -1);
      else begin e = fall_q.pop_front(); check("unlock_at_valid_bit", vcount, e); end
    end
    prev_locked = locked;
    if (err_pulse === 1'b1) begin
      if (pulse_q.size() == 0) check("unexpected_err_pulse", vcount, -1);
      else begin e = pulse_q.pop_front(); check("err_pulse_at_valid_bit", vcount, e); end
    end
    if (snap_req && (snap_q.size() != 0)) begin
      s = snap_q.pop_front();
      check({s.name, "_locked"}, longint'(locked), longint'(s.exp_locked));
      check({s.name, "_err_cnt"}, longint'(err_cnt), longint'(s.exp_cnt));
      check({s.name, "_err_pulse"}, longint'(err_pulse), 0);
    end
  end

  initial begin
    reset = 1'b0; data_in = 1'b0; valid_in = 1'b0; clear_cnt = 1'b0;

    do_reset(1'b0);
    snap("reset", 1'b0, 16'h0000);

    // Clean lfsr stream: lock after the 23rd valid bit (window starts at bit 24)
    gen = 7'b0000001;
    lock_q.push_back(23);
    repeat (500) send_prbs(1'b0, 1'b0);
    snap("clean_500", 1'b1, 16'h0000);

    // Single inverted bit at 501
    pulse_q.push_back(vcount + 1);
    send_prbs(1'b1, 1'b0);
    repeat (38) send_prbs(1'b0, 1'b0);
    snap("single_err", 1'b1, 16'h0001);
    drive(1'b0, 1'b0, 1'b1);
    snap("clear_cnt", 1'b1, 16'h0000);

    // Four errors at bits 540/542/544/546, all inside the window 536..567
    fall_q.push_back(546);
    lock_q.push_back(546 + 23);
    for (int i = 0; i < 7; i++) begin
      if ((i % 2) == 0) begin
        pulse_q.push_back(vcount + 1);
        send_prbs(1'b1, 1'b0);
      end else begin
        send_prbs(1'b0, 1'b0);
      end
    end
    repeat (54) send_prbs(1'b0, 1'b0);
    snap("relock", 1'b1, 16'h0004);

    // Valid toggling: lock counts valid bits only
    do_reset(1'b1);
    gen = 7'b0000001;
    lock_q.push_back(23);
    repeat (60) begin
      send_prbs(1'b0, 1'b0);
      idle();
    end
    snap("toggle_valid", 1'b1, 16'h0000);

    // Saturation from a preloaded count, then clear racing an error
    @(negedge clk);
    valid_in = 1'b0;
    force dut.err_cnt_r = 16'hFFFE;
    @(negedge clk);
    release dut.err_cnt_r;
    snap("preload", 1'b1, 16'hFFFE);
    for (int i = 0; i < 5; i++) begin
      if ((i % 2) == 0) begin
        pulse_q.push_back(vcount + 1);
        send_prbs(1'b1, 1'b0);
      end else begin
        send_prbs(1'b0, 1'b0);
      end
    end
    snap("saturate", 1'b1, 16'hFFFF);
    repeat (23) send_prbs(1'b0, 1'b0);
    pulse_q.push_back(vcount + 1);
    send_prbs(1'b1, 1'b1);
    snap("clear_wins", 1'b1, 16'h0000);

    // Reset mid-lock, then reacquire on the continuing stream
    do_reset(1'b1);
    snap("reset_midlock", 1'b0, 16'h0000);
    lock_q.push_back(23);
    repeat (30) send_prbs(1'b0, 1'b0);
    snap("reacquire", 1'b1, 16'h0000);

    // All-zero input never locks
    do_reset(1'b1);
    repeat (300) drive(1'b0, 1'b1, 1'b0);
    snap("all_zero", 1'b0, 16'h0000);

    repeat (3) @(negedge clk);
    check("lock_events_left", lock_q.size(), 0);
    check("unlock_events_left", fall_q.size(), 0);
    check("err_pulses_left", pulse_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
